// File: rtl/de2_key_debouncer_if.sv
// Signal bundle between the raw DE2 push-buttons and the debouncer outputs.
// The master side drives the raw key levels; the slave side is the debouncer.
interface de2_key_debouncer_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_out;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] busy;

    modport master (
        output key_in,
        input  key_out,
        input  press_pulse,
        input  release_pulse,
        input  busy
    );

    modport slave (
        input  key_in,
        output key_out,
        output press_pulse,
        output release_pulse,
        output busy
    );
endinterface

// File: rtl/de2_key_debouncer.sv
// Per-key debouncer for active-low DE2 push-buttons: 2-FF synchronizer, then a
// four-state stability FSM per channel producing a clean level plus press/release strobes.
module de2_key_debouncer #(
    parameter int NUM_KEYS      = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic              clk,
    input  logic              reset,
    de2_key_debouncer_if.slave keys
);
    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] s_reg;
    logic [NUM_KEYS-1:0] key_out_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;
    logic [NUM_KEYS-1:0] busy_vec;

    // Idle level is all-ones so a reset never looks like a press downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            s_reg     <= '1;
        end else begin
            sync1_reg <= keys.key_in;
            s_reg     <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            state_t               state_reg, state_next;
            logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
            logic                 out_reg, out_next;
            logic                 press_reg, press_next;
            logic                 release_reg, release_next;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg   <= RELEASED;
                    cnt_reg     <= '0;
                    out_reg     <= 1'b1;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    out_reg     <= out_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                out_next     = out_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                case (state_reg)
                    RELEASED: begin
                        out_next = 1'b1;
                        if (!s_reg[gi]) begin
                            state_next = WAIT_PRESS;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    WAIT_PRESS: begin
                        if (s_reg[gi]) begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                            out_next   = 1'b0;
                            press_next = 1'b1;
                        end else begin
                            cnt_next   = cnt_reg + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        out_next = 1'b0;
                        if (s_reg[gi]) begin
                            state_next = WAIT_RELEASE;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!s_reg[gi]) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next   = RELEASED;
                            cnt_next     = '0;
                            out_next     = 1'b1;
                            release_next = 1'b1;
                        end else begin
                            cnt_next     = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                        out_next   = 1'b1;
                    end
                endcase
            end

            assign key_out_vec[gi] = out_reg;
            assign press_vec[gi]   = press_reg;
            assign release_vec[gi] = release_reg;
            assign busy_vec[gi]    = (state_reg == WAIT_PRESS) || (state_reg == WAIT_RELEASE);
        end
    endgenerate

    assign keys.key_out       = key_out_vec;
    assign keys.press_pulse   = press_vec;
    assign keys.release_pulse = release_vec;
    assign keys.busy          = busy_vec;
endmodule

// File: tb/tb_de2_key_debouncer.sv
// Bench for de2_key_debouncer: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key activity.
module tb_de2_key_debouncer;
    localparam int N      = 4;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    de2_key_debouncer_if #(.NUM_KEYS(N)) bus ();

    de2_key_debouncer #(
        .NUM_KEYS(N),
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the level flips once the synchronized sample has disagreed with it
    // for STABLE consecutive clocks; any agreeing sample clears the run.
    logic [N-1:0] m_sync1 = '1;
    logic [N-1:0] m_s     = '1;
    logic [N-1:0] m_out   = '1;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    int           m_run [N];

    initial for (int i = 0; i < N; i++) m_run[i] = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sync1 <= '1;
            m_s     <= '1;
            m_out   <= '1;
            m_press <= '0;
            m_rel   <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_press[i] <= 1'b0;
                m_rel[i]   <= 1'b0;
                if (m_s[i] == m_out[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] + 1 >= STABLE) begin
                    m_run[i]   <= 0;
                    m_out[i]   <= m_s[i];
                    m_press[i] <= ~m_s[i];
                    m_rel[i]   <= m_s[i];
                end else begin
                    m_run[i] <= m_run[i] + 1;
                end
            end
            m_s     <= m_sync1;
            m_sync1 <= bus.key_in;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_busy;
        for (int i = 0; i < N; i++) exp_busy[i] = (m_run[i] != 0);
        check("model_key_out", bus.key_out, m_out);
        check("model_press", bus.press_pulse, m_press);
        check("model_release", bus.release_pulse, m_rel);
        check("model_busy", bus.busy, exp_busy);
    end

    task automatic drive(input logic [N-1:0] v);
        @(posedge clk);
        #1 bus.key_in = v;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        bus.key_in = '1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        settle(20);
        check("rst_key_out", bus.key_out, 4'hF);
        check("rst_press", bus.press_pulse, 4'h0);
        check("rst_release", bus.release_pulse, 4'h0);
        check("rst_busy", bus.busy, 4'h0);

        // Clean press on key 0; loop index k means "just after edge E0+k".
        drive(4'hE);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 6; k++) begin
            check("k0_busy", N'(bus.busy[0]), N'((k >= 2 && k <= 4) ? 1 : 0));
            check("k0_key_out", bus.key_out, (k >= 5) ? 4'hE : 4'hF);
            check("k0_press", bus.press_pulse, (k == 5) ? 4'h1 : 4'h0);
            @(negedge clk);
        end
        drive(4'hF);
        settle(10);

        // Bouncing key 1, then held low.
        for (int b = 0; b < 4; b++) begin
            drive((b % 2 == 0) ? 4'hD : 4'hF);
            @(posedge clk);
        end
        drive(4'hD);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 6; k++) begin
            check("k1_key_out", N'(bus.key_out[1]), N'((k >= 5) ? 0 : 1));
            check("k1_press", N'(bus.press_pulse[1]), N'((k == 5) ? 1 : 0));
            @(negedge clk);
        end
        drive(4'hF);
        settle(10);

        // Keys 0 and 3 together.
        drive(4'h6);
        @(posedge clk);
        @(negedge clk);
        settle(5);
        check("sim_key_out", bus.key_out, 4'h6);
        check("sim_press", bus.press_pulse, 4'h9);
        settle(1);
        check("sim_press_end", bus.press_pulse, 4'h0);
        drive(4'hF);
        @(posedge clk);
        @(negedge clk);
        settle(5);
        check("sim_release", bus.release_pulse, 4'h9);
        check("sim_rel_key_out", bus.key_out, 4'hF);
        settle(1);
        check("sim_release_end", bus.release_pulse, 4'h0);
        settle(5);

        // Reset while key 2 is mid-wait.
        drive(4'hB);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rw_busy", bus.busy, 4'h4);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rw_key_out", bus.key_out, 4'hF);
        check("rw_busy_rst", bus.busy, 4'h0);
        check("rw_press_rst", bus.press_pulse, 4'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            check("rw_press", bus.press_pulse, (k == 6) ? 4'h4 : 4'h0);
            check("rw_key_out2", bus.key_out, (k >= 6) ? 4'hB : 4'hF);
            @(negedge clk);
        end
        drive(4'hF);
        settle(10);

        // Repeated 3-cycle low glitches on key 3.
        for (int g = 0; g < 10; g++) begin
            drive(4'h7);
            repeat (3) begin
                @(negedge clk);
                check("gl_key_out", N'(bus.key_out[3]), N'(1));
                check("gl_press", N'(bus.press_pulse[3]), N'(0));
            end
            drive(4'hF);
            repeat (3) @(negedge clk);
        end
        settle(8);

        // Randomized activity, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            @(posedge clk);
            #1;
            v = bus.key_in;
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) v[i] = ~v[i];
            bus.key_in = v;
            if ($urandom_range(299) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        bus.key_in = '1;
        settle(12);
        check("end_key_out", bus.key_out, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
